lfsr_timer_arbiter: RTL and testbench

Shares one `countdown` timer core among `N_REQ` requesters that each need a fixed delay of `COUNT` enabled cycles. Requesters are served one at a time in round-robin order. For each grant the arbiter clears the core, runs it, and returns a one-cycle done pulse to the winner. The block sits between protocol engines that need timeouts and a single LFSR countdown instance, which saves one LFSR per requester.

---
 rtl/lfsr_timer_arbiter.sv | 143 ++++++++++++++
 tb/tb_lfsr_timer_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_timer_arbiter.sv
// Round-robin arbiter that shares one LFSR countdown core among N_REQ requesters.
// Each grant clears the core, runs COUNT enabled cycles, then pulses o_done to the winner.

module countdown #(
  parameter int COUNT = 100
) (
  input  logic clock,
  input  logic i_rst_n,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_done,
  output logic o_expire
);
  localparam logic [15:0] SEED = 16'h0001;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // State the LFSR holds during the COUNT-th enabled cycle.
  function automatic logic [15:0] lfsr_term(input int n);
    logic [15:0] s;
    s = SEED;
    for (int k = 1; k < n; k++) s = lfsr_step(s);
    return s;
  endfunction

  localparam logic [15:0] TERM = lfsr_term(COUNT);

  logic [15:0] r_lfsr;
  logic        r_done;

  assign o_expire = i_enable & ~i_reset & ~r_done & (r_lfsr == TERM);
  assign o_done   = r_done;

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= SEED;
      r_done <= 1'b0;
    end else if (i_reset) begin
      r_lfsr <= SEED;
      r_done <= 1'b0;
    end else if (i_enable && !r_done) begin
      r_lfsr <= lfsr_step(r_lfsr);
      if (r_lfsr == TERM) r_done <= 1'b1;
    end
  end
endmodule

module lfsr_timer_arbiter #(
  parameter int N_REQ = 4,
  parameter int COUNT = 100,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             i_reset_n,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_pause,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_active_id,
  output logic [N_REQ-1:0] o_done,
  output logic             o_busy
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  localparam logic [ID_W:0]   NREQ_W = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0] LAST   = ID_W'(N_REQ - 1);

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_ptr, r_active_id, w_win, w_ptr_nxt;
  logic [N_REQ-1:0] r_grant, r_done;
  logic [ID_W:0]    w_idx;
  logic             w_found, w_take, w_abort;
  logic             w_core_done, w_core_expire;

  countdown #(.COUNT(COUNT)) u_core (
    .clock    (clock),
    .i_rst_n  (i_reset_n),
    .i_reset  (r_state != RUN),
    .i_enable ((r_state == RUN) & ~i_pause),
    .o_done   (w_core_done),
    .o_expire (w_core_expire)
  );

  // First requester at or after r_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(i);
      if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
      if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_ptr_nxt = (r_active_id == LAST) ? '0 : r_active_id + ID_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE:  if (w_found) begin w_take = 1'b1; w_state_nxt = CLEAR; end
      CLEAR: if (!i_req[r_active_id]) begin w_abort = 1'b1; w_state_nxt = IDLE; end
             else w_state_nxt = RUN;
      // The expire strobe lets DONE land on the cycle right after the last enabled cycle.
      RUN:   if (!i_req[r_active_id]) begin w_abort = 1'b1; w_state_nxt = IDLE; end
             else if (w_core_expire || w_core_done) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_active_id <= '0;
      r_grant     <= '0;
      r_done      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= '0;
      if (w_take) begin
        r_active_id <= w_win;
        r_grant     <= N_REQ'(1) << w_win;
      end else if (w_state_nxt == IDLE || w_state_nxt == DONE) begin
        r_grant <= '0;
      end
      if (r_state == RUN && w_state_nxt == DONE) r_done <= N_REQ'(1) << r_active_id;
      if (w_abort || r_state == DONE) r_ptr <= w_ptr_nxt;
    end
  end

  assign o_grant     = r_grant;
  assign o_done      = r_done;
  assign o_active_id = r_active_id;
  assign o_busy      = (r_state != IDLE);
endmodule

// File: tb/tb_lfsr_timer_arbiter.sv
// Bench for lfsr_timer_arbiter: directed scenarios plus random traffic, all scored
// against a service-level model of the round-robin timer.

module tb_lfsr_timer_arbiter;
  localparam int N   = 4;
  localparam int CNT = 20;
  localparam int IW  = 2;

  logic          clock = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_pause = 1'b0;
  logic [N-1:0]  i_req = '0;
  logic [N-1:0]  o_grant, o_done;
  logic [IW-1:0] o_active_id;
  logic          o_busy;

  always #5 clock = ~clock;

  lfsr_timer_arbiter #(.N_REQ(N), .COUNT(CNT)) dut (
    .clock       (clock),
    .i_reset_n   (i_reset_n),
    .i_req       (i_req),
    .i_pause     (i_pause),
    .o_grant     (o_grant),
    .o_active_id (o_active_id),
    .o_done      (o_done),
    .o_busy      (o_busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: the requester being served, how many enabled cycles it still needs,
  // whether its first (clear) cycle is pending, and who gets a pulse this cycle.
  int m_owner, m_clr, m_left, m_pulse, m_ptr, m_last;

  function automatic int oh(input int id);
    return (id >= 0) ? (1 << id) : 0;
  endfunction

  function automatic int oh2id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_clr = 0; m_left = 0; m_pulse = -1; m_ptr = 0; m_last = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic pause);
    if (m_pulse >= 0) begin
      m_pulse = -1;
    end else if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else if (m_clr != 0) begin
        m_clr = 0;
      end else if (!pause) begin
        m_left--;
        if (m_left == 0) begin
          m_pulse = m_owner;
          m_ptr = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else if (req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
      m_last = m_owner; m_clr = 1; m_left = CNT;
    end
  endtask

  task automatic tick(input logic [N-1:0] req, input logic pause);
    i_req = req; i_pause = pause;
    model_step(req, pause);
    @(posedge clock); @(negedge clock);
    chk("grant",  32'(o_grant), 32'(oh(m_owner)));
    chk("done",   32'(o_done), 32'(oh(m_pulse)));
    chk("busy",   32'(o_busy), 32'((m_owner >= 0 || m_pulse >= 0) ? 1 : 0));
    chk("active", 32'(o_active_id), 32'(m_last));
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    #2;
    chk("rst_grant",  32'(o_grant), 0);
    chk("rst_done",   32'(o_done), 0);
    chk("rst_busy",   32'(o_busy), 0);
    chk("rst_active", 32'(o_active_id), 0);
    model_reset();
    @(posedge clock); @(negedge clock);
    i_reset_n = 1'b1; i_req = '0; i_pause = 1'b0;
  endtask

  // Holds req until a done pulse, optional pause window [p0,p1]; returns done latency.
  task automatic serve(input logic [N-1:0] req, input int p0, input int p1, output int lat, output int gcnt);
    lat = -1; gcnt = 0;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      tick(req, (k >= p0 && k <= p1));
      if (o_grant != '0) gcnt++;
      if (o_done != '0) lat = k + 1;
    end
  endtask

  initial begin
    int lat, gcnt, nd;
    int dcyc[8], did[8];
    logic [N-1:0] rq;
    model_reset();
    do_reset();
    repeat (3) tick('0, 1'b0);

    // Single request: done at t+COUNT+2, grant for COUNT+1 cycles, idle after.
    serve(4'b0001, -1, -1, lat, gcnt);
    chk("t1_latency", lat, CNT + 2);
    chk("t1_grant_cycles", gcnt, CNT + 1);
    tick('0, 1'b0);
    chk("t1_busy_after", 32'(o_busy), 0);

    // All requesting: round-robin 0,1,2,3,0 at COUNT+3 spacing.
    do_reset();
    for (int i = 0; i < 8; i++) begin dcyc[i] = -1; did[i] = -1; end
    nd = 0;
    for (int k = 0; k < 5 * (CNT + 3) + 5; k++) begin
      tick(4'b1111, 1'b0);
      if (o_done != '0 && nd < 8) begin dcyc[nd] = k; did[nd] = oh2id(o_done); nd++; end
    end
    for (int i = 0; i < 5; i++) chk("t2_order", did[i], i % N);
    for (int i = 1; i < 5; i++) chk("t2_spacing", dcyc[i] - dcyc[i-1], CNT + 3);

    // Five pause cycles in mid-RUN stretch latency by five.
    do_reset();
    serve(4'b0001, 8, 12, lat, gcnt);
    chk("t3_pause_latency", lat, CNT + 7);
    tick('0, 1'b0);

    // Winner abandons 10 cycles into RUN; requester 2 granted two cycles later.
    do_reset();
    for (int k = 0; k < 12; k++) tick(4'b0101, 1'b0);
    tick(4'b0100, 1'b0);
    chk("t4_grant_drop", 32'(o_grant), 0);
    chk("t4_no_done", 32'(o_done), 0);
    tick(4'b0100, 1'b0);
    chk("t4_next_grant", 32'(o_grant), 32'(4'b0100));
    for (int k = 0; k < CNT + 4; k++) tick(4'b0100, 1'b0);
    tick('0, 1'b0);

    // Drop on the last enabled cycle: abort wins, ptr still advances.
    do_reset();
    for (int k = 0; k < CNT + 1; k++) tick(4'b0001, 1'b0);
    tick('0, 1'b0);
    chk("t5_no_done", 32'(o_done), 0);
    chk("t5_idle", 32'(o_busy), 0);
    tick(4'b0011, 1'b0);
    chk("t5_ptr_moved", 32'(o_grant), 32'(4'b0010));
    for (int k = 0; k < CNT + 2; k++) tick(4'b0010, 1'b0);
    tick('0, 1'b0);

    // Reset mid-RUN of requester 1; afterwards requester 0 wins with full latency.
    do_reset();
    serve(4'b0011, -1, -1, lat, gcnt);
    for (int k = 0; k < 12; k++) tick(4'b0011, 1'b0);
    chk("t6_pre_grant", 32'(o_grant), 32'(4'b0010));
    do_reset();
    serve(4'b0011, -1, -1, lat, gcnt);
    chk("t6_latency", lat, CNT + 2);
    chk("t6_winner", 32'(o_done), 32'(4'b0001));

    // Random traffic: requests rise, sometimes abandon, sometimes re-request after done.
    do_reset();
    rq = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) begin
        if (m_pulse == i) rq[i] = ($urandom_range(0, 9) < 3);
        else if (rq[i]) rq[i] = ($urandom_range(0, 59) != 0);
        else rq[i] = ($urandom_range(0, 7) == 0);
      end
      tick(rq, ($urandom_range(0, 4) == 0));
      if (k == 1000 || k == 2200) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
